// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// State encodings, default cycle counts and the per-channel event bundle.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    BTN_ST_RELEASED        = 2'd0,
    BTN_ST_PRESS_PENDING   = 2'd1,
    BTN_ST_PRESSED         = 2'd2,
    BTN_ST_RELEASE_PENDING = 2'd3
  } btn_st_e;

  // 10 ms and 1 s at 27 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 270000;
  localparam int unsigned DEF_LONG_CYCLES     = 27000000;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic lng;
  } btn_evt_t;

  function automatic logic st_is_down(btn_st_e st);
    return (st == BTN_ST_PRESSED) ||
           (st == BTN_ST_RELEASE_PENDING);
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button pin / event bundle between the board pins and the peripheral.
// master drives raw pins, slave (the debouncer) drives the events.
interface btn_debounce_if #(
  parameter int N_BTN = 2
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );

endinterface

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop sync, debounce FSM, stability counter, hold counter.
// Long-press detection only with BTN_LONG_PRESS_EN defined.
import btn_debounce_pkg::*;

module btn_debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int          CNT_WIDTH       = 32,
  parameter int          ACTIVE_LOW      = 1,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     raw,
  output btn_evt_t evt
);

  localparam logic IDLE = (ACTIVE_LOW != 0);
  localparam bit   SKIP = (DEBOUNCE_CYCLES == 1);

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  localparam logic [CNT_WIDTH-1:0] ONE  =
    CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LONGV =
    CNT_WIDTH'(LONG_CYCLES);

  logic [1:0]           sync;
  logic                 s;
  btn_st_e              st;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 press;
  logic                 rel;
  logic                 lng;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {2{IDLE}};
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // 1 = pressed, whatever the pin polarity
  assign s = sync[1] ^ IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= BTN_ST_RELEASED;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      unique case (st)
        BTN_ST_RELEASED: begin
          if (s) begin
            if (SKIP) begin
              st    <= BTN_ST_PRESSED;
              cnt   <= '0;
              press <= 1'b1;
            end else begin
              st  <= BTN_ST_PRESS_PENDING;
              cnt <= ONE;
            end
          end
        end
        BTN_ST_PRESS_PENDING: begin
          if (!s) begin
            st  <= BTN_ST_RELEASED;
            cnt <= '0;
          end else if (cnt == LAST) begin
            st    <= BTN_ST_PRESSED;
            cnt   <= '0;
            press <= 1'b1;
          end else if (cnt != CMAX) begin
            cnt <= cnt + ONE;
          end
        end
        BTN_ST_PRESSED: begin
          if (!s) begin
            if (SKIP) begin
              st  <= BTN_ST_RELEASED;
              cnt <= '0;
              rel <= 1'b1;
            end else begin
              st  <= BTN_ST_RELEASE_PENDING;
              cnt <= ONE;
            end
          end
        end
        BTN_ST_RELEASE_PENDING: begin
          if (s) begin
            st  <= BTN_ST_PRESSED;
            cnt <= '0;
          end else if (cnt == LAST) begin
            st  <= BTN_ST_RELEASED;
            cnt <= '0;
            rel <= 1'b1;
          end else if (cnt != CMAX) begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          st  <= BTN_ST_RELEASED;
          cnt <= '0;
        end
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  logic [CNT_WIDTH-1:0] hold;

  // Runs only while steadily pressed; paused during a release bounce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
      lng  <= 1'b0;
    end else begin
      lng <= 1'b0;
      if (!st_is_down(st)) begin
        hold <= '0;
      end else if (st == BTN_ST_PRESSED && s &&
                   hold != LONGV) begin
        hold <= hold + ONE;
        if (hold == LONGV - ONE) begin
          lng <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_long;
  assign unused_long = ^LONGV;
  assign lng         = 1'b0;
`endif

  assign evt = '{
    level: st_is_down(st),
    press: press,
    rel:   rel,
    lng:   lng
  };

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: N_BTN independent debounce channels.
// Define BTN_LONG_PRESS_EN to enable the long-press pulse.
import btn_debounce_pkg::*;

module btn_debounce #(
  parameter int          N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int          CNT_WIDTH       = 32,
  parameter int          ACTIVE_LOW      = 1,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input logic           clk,
  input logic           rst_n,
  btn_debounce_if.slave bus
);

  btn_evt_t evt [N_BTN];

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.btn_raw[i]),
      .evt   (evt[i])
    );

    assign bus.btn_level[i]   = evt[i].level;
    assign bus.btn_press[i]   = evt[i].press;
    assign bus.btn_release[i] = evt[i].rel;
    assign bus.btn_long[i]    = evt[i].lng;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: per-cycle vector table plus
// hand-written bounce/latency sequences on channel 1.
module tb_btn_debounce;

  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 8;

`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  btn_debounce_if #(.N_BTN(N)) bus ();

  btn_debounce #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .CNT_WIDTH       (32),
    .ACTIVE_LOW      (1),
    .LONG_CYCLES     (L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
  } vec_t;

  vec_t tbl[$];
  int   pass_cnt = 0;
  int   total    = 0;

  function automatic void add(logic r, logic [1:0] raw,
                              logic [1:0] lvl, logic [1:0] prs,
                              logic [1:0] rel, logic [1:0] lng);
    vec_t v;
    v.rst = r;
    v.raw = raw;
    v.lvl = lvl;
    v.prs = prs;
    v.rel = rel;
    v.lng = lng;
    tbl.push_back(v);
  endfunction

  function automatic void idle(logic r, logic [1:0] raw,
                               logic [1:0] lvl, int n);
    for (int k = 0; k < n; k++) add(r, raw, lvl, 2'b00, 2'b00, 2'b00);
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic cyc(logic r, logic [1:0] raw);
    rst_n       = r;
    bus.btn_raw = raw;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] outs();
    return {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long};
  endfunction

  initial begin
    logic [1:0] l0;
    logic [1:0] l1;
    int         lat;
    bit         seen;
    bit         bad;

    l0 = LONG_ON ? 2'b01 : 2'b00;
    l1 = LONG_ON ? 2'b10 : 2'b00;

    rst_n       = 1'b0;
    bus.btn_raw = 2'b11;
    @(negedge clk);

    // reset, then quiet
    idle(0, 2'b11, 2'b00, 3);
    idle(1, 2'b11, 2'b00, 20);
    // clean press on ch0, held 12 clk
    idle(1, 2'b10, 2'b00, 5);
    add(1, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    idle(1, 2'b10, 2'b01, 6);
    // release; hold counter hits 8 during sync lag
    add(1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 2'b11, 2'b01, 2'b00, 2'b00, l0);
    idle(1, 2'b11, 2'b01, 3);
    add(1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    idle(1, 2'b11, 2'b00, 4);
    // press bounce rejected
    idle(1, 2'b10, 2'b00, 3);
    idle(1, 2'b11, 2'b00, 2);
    idle(1, 2'b10, 2'b00, 3);
    idle(1, 2'b11, 2'b00, 6);
    // simultaneous press and release
    idle(1, 2'b00, 2'b00, 5);
    add(1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    idle(1, 2'b00, 2'b11, 4);
    idle(1, 2'b11, 2'b11, 5);
    add(1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    idle(1, 2'b11, 2'b00, 4);
    // reset mid-press, button held through it
    idle(1, 2'b10, 2'b00, 3);
    idle(0, 2'b10, 2'b00, 1);
    idle(1, 2'b10, 2'b00, 5);
    add(1, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    idle(1, 2'b10, 2'b01, 2);
    idle(1, 2'b11, 2'b01, 5);
    add(1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    idle(1, 2'b11, 2'b00, 3);
    // long hold on ch1
    idle(1, 2'b01, 2'b00, 5);
    add(1, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00);
    idle(1, 2'b01, 2'b10, 7);
    add(1, 2'b01, 2'b10, 2'b00, 2'b00, l1);
    idle(1, 2'b01, 2'b10, 16);
    idle(1, 2'b11, 2'b10, 5);
    add(1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00);
    idle(1, 2'b11, 2'b00, 3);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].raw);
      check($sformatf("vec%0d lvl/prs/rel/lng", i), 32'(outs()),
            32'({tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].lng}));
    end

    // ch1 press latency with a bounded wait
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      cyc(1, 2'b01);
      if (bus.btn_press[1]) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("press1_latency", 32'(lat), 32'd6);
    check("press1_level", 32'(bus.btn_level), 32'h2);

    // short release bounce must not drop the level
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, (i < 2) ? 2'b11 : 2'b01);
      if (bus.btn_release[1] || !bus.btn_level[1] || bus.btn_press[1])
        bad = 1'b1;
    end
    check("release_bounce", 32'(bad), 32'd0);

    // ch1 release latency with a bounded wait
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      cyc(1, 2'b11);
      if (bus.btn_release[1]) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("release1_latency", 32'(lat), 32'd6);
    check("release1_level", 32'(bus.btn_level), 32'h0);

    cyc(1, 2'b11);
    check("quiet_after", 32'(outs()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
